// File: rtl/sr_seq_pkg.sv
// Shared types for the shift register sequencer.
// Holds the FSM state encoding and the default register width.
package sr_seq_pkg;

    localparam int NBITS_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        CHECK,
        DONE
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a last-grant register.
// Ports: clk, reset (async, active-low), req[1:0], done, done_id -> gnt_id.
import sr_seq_pkg::*;

module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       done,
    input  logic       done_id,
    output logic       gnt_id
);

    logic r_last_grant;

    // On a tie the requester not served last wins.
    always_comb begin
        gnt_id = 1'b0;
        unique case (req)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ~r_last_grant;
            default: gnt_id = 1'b0;
        endcase
    end

    // Reset value 1 lets requester 0 win the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_last_grant <= 1'b1;
        else if (done)
            r_last_grant <= done_id;
    end

endmodule

// File: rtl/shift_reg_sequencer.sv
// Loads a granted byte into an external right-shift register, LSB first,
// reads it back and flags a mismatch. Ports: clk, reset (async, active-low),
// req/data0/data1 requester side, abort, sr_po in; sr_reset/sr_en/sr_ser
// to the register, ack/busy/result/err status out.
import sr_seq_pkg::*;

module shift_reg_sequencer #(
    parameter int NBITS = NBITS_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [NBITS-1:0] data0,
    input  logic [NBITS-1:0] data1,
    input  logic             abort,
    input  logic [NBITS-1:0] sr_po,
    output logic             sr_reset,
    output logic             sr_en,
    output logic             sr_ser,
    output logic [1:0]       ack,
    output logic             busy,
    output logic [NBITS-1:0] result,
    output logic             err
);

    localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [NBITS-1:0] r_shadow;
    logic [NBITS-1:0] r_result;
    logic             r_err;
    logic             r_gnt;
    logic             w_gnt_id;
    logic             w_last;

    assign w_last = (r_cnt == CW'(NBITS - 1));
    assign result = r_result;
    assign err    = r_err;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .done    (r_state == DONE),
        .done_id (r_gnt),
        .gnt_id  (w_gnt_id)
    );

    always_comb begin
        w_next   = r_state;
        sr_reset = 1'b0;
        sr_en    = 1'b0;
        sr_ser   = 1'b0;
        ack      = 2'b00;
        busy     = (r_state != IDLE);
        unique case (r_state)
            IDLE: begin
                if (|req)
                    w_next = CLEAR;
            end
            CLEAR: begin
                sr_reset = 1'b1;
                w_next   = abort ? IDLE : SHIFT;
            end
            SHIFT: begin
                sr_en  = 1'b1;
                sr_ser = r_shadow[r_cnt];
                if (abort)
                    w_next = IDLE;
                else if (w_last)
                    w_next = CHECK;
            end
            CHECK: begin
                w_next = abort ? IDLE : DONE;
            end
            DONE: begin
                ack    = r_gnt ? 2'b10 : 2'b01;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_gnt    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && |req) begin
                r_gnt    <= w_gnt_id;
                r_shadow <= w_gnt_id ? data1 : data0;
            end
            // Counter holds at its top value; cleared on entry to SHIFT.
            if (r_state == CLEAR)
                r_cnt <= '0;
            else if (r_state == SHIFT && !w_last && !abort)
                r_cnt <= r_cnt + 1'b1;
            if (r_state == CHECK && !abort) begin
                r_result <= sr_po;
                r_err    <= (sr_po != r_shadow);
            end
        end
    end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench for shift_reg_sequencer with a behavioural
// right-shift register model on the sr_* side.
module tb_shift_reg_sequencer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req;
    logic [N-1:0] data0;
    logic [N-1:0] data1;
    logic         abort;
    logic [N-1:0] sr_po;
    logic         sr_reset;
    logic         sr_en;
    logic         sr_ser;
    logic [1:0]   ack;
    logic         busy;
    logic [N-1:0] result;
    logic         err;

    logic [N-1:0] po_model = '0;
    logic         force_zero = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sr_reset)
            po_model <= '0;
        else if (sr_en)
            po_model <= {sr_ser, po_model[N-1:1]};
    end

    assign sr_po = force_zero ? '0 : po_model;

    shift_reg_sequencer #(.NBITS(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .data0    (data0),
        .data1    (data1),
        .abort    (abort),
        .sr_po    (sr_po),
        .sr_reset (sr_reset),
        .sr_en    (sr_en),
        .sr_ser   (sr_ser),
        .ack      (ack),
        .busy     (busy),
        .result   (result),
        .err      (err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Starts in IDLE with req already driven; returns the cycle count
    // from the grant edge to the ack cycle (bounded).
    task automatic run_xfer(output int n, output logic [1:0] a);
        n = 0;
        tick;
        n = 1;
        while (ack == 2'b00 && n < 40) begin
            tick;
            n++;
        end
        a = ack;
    endtask

    task automatic test_reset;
        logic [15:0] outs;
        reset = 1'b0;
        req   = 2'b00;
        data0 = '0;
        data1 = '0;
        abort = 1'b0;
        tick;
        tick;
        outs = {sr_reset, sr_en, sr_ser, ack, busy, err, 1'b0, result};
        vectors++;
        if (outs !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_outs got %h want 0000", outs);
        end
        reset = 1'b1;
    endtask

    task automatic test_single;
        logic [N-1:0] v;
        int n;
        v     = 8'hA5;
        req   = 2'b01;
        data0 = v;
        tick;
        n = 1;
        vectors++;
        if ({sr_reset, sr_en, busy} !== 3'b101) begin
            miscompares++;
            $display("FAIL clear_cycle got %b want 101",
                     {sr_reset, sr_en, busy});
        end
        for (int i = 0; i < N; i++) begin
            tick;
            n++;
            vectors++;
            if ({sr_reset, sr_en, sr_ser} !== {2'b01, v[i]}) begin
                miscompares++;
                $display("FAIL shift_bit%0d got %b want %b", i,
                         {sr_reset, sr_en, sr_ser}, {2'b01, v[i]});
            end
        end
        tick;
        n++;
        vectors++;
        if (ack !== 2'b00 || sr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL check_cycle got ack=%b en=%b want 00/0",
                     ack, sr_en);
        end
        tick;
        n++;
        vectors++;
        if (ack !== 2'b01) begin
            miscompares++;
            $display("FAIL single_ack n=%0d got %b want 01", n, ack);
        end
        vectors++;
        if (result !== 8'hA5 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL single_res got %h/%b want a5/0", result, err);
        end
        req = 2'b00;
        tick;
        vectors++;
        if (busy !== 1'b0 || ack !== 2'b00) begin
            miscompares++;
            $display("FAIL single_idle got busy=%b ack=%b want 0/00",
                     busy, ack);
        end
    endtask

    task automatic test_tie;
        int n;
        logic [1:0] a;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        req   = 2'b11;
        data0 = 8'h0F;
        data1 = 8'hF0;
        run_xfer(n, a);
        vectors++;
        if (n !== 11 || a !== 2'b01 || result !== 8'h0F) begin
            miscompares++;
            $display("FAIL tie_first got n=%0d ack=%b res=%h want 11/01/0f",
                     n, a, result);
        end
        tick;
        run_xfer(n, a);
        vectors++;
        if (n !== 11 || a !== 2'b10 || result !== 8'hF0) begin
            miscompares++;
            $display("FAIL tie_second got n=%0d ack=%b res=%h want 11/10/f0",
                     n, a, result);
        end
        req = 2'b00;
        tick;
    endtask

    task automatic test_err;
        int n;
        logic [1:0] a;
        req   = 2'b01;
        data0 = 8'h3C;
        tick;
        repeat (9) tick;
        force_zero = 1'b1;
        tick;
        force_zero = 1'b0;
        vectors++;
        if (ack !== 2'b01 || result !== 8'h00 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_set got ack=%b res=%h err=%b want 01/00/1",
                     ack, result, err);
        end
        req = 2'b00;
        tick;
        req = 2'b01;
        run_xfer(n, a);
        vectors++;
        if (n !== 11 || result !== 8'h3C || err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear got n=%0d res=%h err=%b want 11/3c/0",
                     n, result, err);
        end
        req = 2'b00;
        tick;
    endtask

    task automatic test_abort;
        int n;
        logic [1:0] a;
        req   = 2'b10;
        data1 = 8'h5A;
        tick;
        repeat (4) tick;
        vectors++;
        if (sr_en !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_pre got en=%b want 1", sr_en);
        end
        abort = 1'b1;
        tick;
        abort = 1'b0;
        vectors++;
        if (busy !== 1'b0 || ack !== 2'b00 || result !== 8'h3C) begin
            miscompares++;
            $display("FAIL abort_idle got busy=%b ack=%b res=%h want 0/00/3c",
                     busy, ack, result);
        end
        run_xfer(n, a);
        vectors++;
        if (n !== 11 || a !== 2'b10 || result !== 8'h5A) begin
            miscompares++;
            $display("FAIL abort_retry got n=%0d ack=%b res=%h want 11/10/5a",
                     n, a, result);
        end
        req = 2'b00;
        tick;
    endtask

    task automatic test_reset_mid;
        int n;
        logic [1:0] a;
        logic [15:0] outs;
        req   = 2'b10;
        data1 = 8'h77;
        tick;
        repeat (3) tick;
        reset = 1'b0;
        #1;
        outs = {sr_reset, sr_en, sr_ser, ack, busy, err, 1'b0, result};
        vectors++;
        if (outs !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_mid got %h want 0000", outs);
        end
        req   = 2'b01;
        data0 = 8'hC3;
        reset = 1'b1;
        run_xfer(n, a);
        vectors++;
        if (n !== 11 || a !== 2'b01 || result !== 8'hC3 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_after got n=%0d ack=%b res=%h want 11/01/c3",
                     n, a, result);
        end
        req = 2'b00;
        tick;
    endtask

    task automatic test_back_to_back;
        int n;
        int g;
        int low;
        logic [1:0] a;
        req   = 2'b01;
        data0 = 8'h96;
        run_xfer(n, a);
        vectors++;
        if (n !== 11 || a !== 2'b01) begin
            miscompares++;
            $display("FAIL b2b_first got n=%0d ack=%b want 11/01", n, a);
        end
        g   = 0;
        low = 0;
        do begin
            tick;
            g++;
            if (busy === 1'b0) begin
                low++;
                abort = 1'b1;
            end else begin
                abort = 1'b0;
            end
        end while (ack == 2'b00 && g < 40);
        abort = 1'b0;
        vectors++;
        if (g !== 12 || ack !== 2'b01 || result !== 8'h96) begin
            miscompares++;
            $display("FAIL b2b_gap got gap=%0d ack=%b res=%h want 12/01/96",
                     g, ack, result);
        end
        vectors++;
        if (low !== 1) begin
            miscompares++;
            $display("FAIL b2b_idle got %0d low cycles want 1", low);
        end
        req = 2'b00;
        tick;
    endtask

    initial begin
        test_reset;
        test_single;
        test_tie;
        test_err;
        test_abort;
        test_reset_mid;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_reg_sequencer.md
SHIFT_REG_SEQUENCER -- requirements
Module: shift_reg_sequencer

Interface
REQ-001 SHALL have parameter NBITS, default 8: width of the shift register it sequences and of every data bus.
REQ-002 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port req, input, 2: level requests from requester 0 and requester 1, each held until its ack.
REQ-005 SHALL have port data0, input, NBITS: byte to be loaded for requester 0.
REQ-006 SHALL have port data1, input, NBITS: byte to be loaded for requester 1.
REQ-007 SHALL have port abort, input, 1: synchronous cancel of the transfer in progress.
REQ-008 SHALL have port sr_po, input, NBITS: parallel output read back from the shift register.
REQ-009 SHALL have port sr_reset, output, 1: synchronous, active-high clear to the shift register.
REQ-010 SHALL have port sr_en, output, 1: shift enable to the shift register.
REQ-011 SHALL have port sr_ser, output, 1: serial data to the shift register, which shifts right so that the next value is {sr_ser, po[NBITS-1:1]}.
REQ-012 SHALL have port ack, output, 2: one-cycle completion pulse to the granted requester.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port result, output, NBITS: sr_po captured at the end of the last completed transfer.
REQ-015 SHALL have port err, output, 1: high when the captured result differs from the granted data; held until the next capture.

Function
REQ-016 SHALL implement the FSM IDLE -> CLEAR -> SHIFT -> CHECK -> DONE -> IDLE.
REQ-017 IDLE with any req bit high SHALL, at that edge (E0): grant one requester, latch its data into a shadow register and go to CLEAR.
REQ-018 CLEAR SHALL last 1 cycle with sr_reset=1, sr_en=0; the register clears at E1.
REQ-019 SHALL stay in SHIFT for exactly NBITS cycles with sr_en=1 and sr_ser=shadow[cnt], cnt counting 0..NBITS-1, LSB first; shifts occur at E2..E(NBITS+1).
REQ-020 CHECK SHALL last 1 cycle; at its closing edge result<=sr_po and err<=(sr_po != shadow).
REQ-021 DONE SHALL last 1 cycle with ack[granted]=1 and return to IDLE; total latency from E0 to the ack cycle is NBITS+3 cycles (11 for NBITS=8).
REQ-022 Outside CLEAR, sr_reset SHALL be 0; outside SHIFT, sr_en and sr_ser SHALL be 0.
REQ-023 Arbitration SHALL be round-robin:
- single request: granted;
- both requests: the one not granted last;
- last_grant updates only on DONE.
REQ-024 A req bit dropped while that requester is granted SHALL NOT affect the transfer in progress.
REQ-025 abort high in CLEAR, SHIFT or CHECK SHALL force IDLE at the next edge:
- no ack, result/err unchanged, last_grant unchanged;
- a held request is re-arbitrated from IDLE.
REQ-026 abort in IDLE or DONE SHALL be ignored.
REQ-027 cnt SHALL be ceil(log2(NBITS)) bits and reset to 0 on every entry to SHIFT; no wrap-around in any state.

Reset
REQ-028 reset low SHALL immediately force: state=IDLE, cnt=0, shadow=0, result=0, err=0, ack=0, sr_reset=0, sr_en=0, sr_ser=0, busy=0, last_grant=1 (requester 0 wins the first tie).
REQ-029 Reset mid-transfer SHALL discard the transfer with no ack; the first edge after release behaves as IDLE.

Structure
REQ-030 Package sr_seq_pkg SHALL hold the state enum (IDLE, CLEAR, SHIFT, CHECK, DONE) and the default NBITS constant.
REQ-031 Sub-module rr_arbiter2 SHALL hold the two-way round-robin grant logic and last_grant; the FSM, counter and shadow register stay in shift_reg_sequencer.

Verification
REQ-032 Bench SHALL pair the block with a behavioural right-shift register and cover these scenarios:
- req=01, data0=8'hA5: sr_reset for 1 cycle, sr_ser sequence 1,0,1,0,0,1,0,1, ack=01 eleven cycles after E0, result=8'hA5, err=0.
- req=11 from reset, data0=8'h0F, data1=8'hF0: requester 0 served first (ack=01), then requester 1 (ack=10, result=8'hF0); requests held high the whole time.
- Bench forces sr_po=8'h00 in CHECK with data=8'h3C: err=1, result=8'h00; the next clean transfer clears err.
- abort on the 4th SHIFT cycle with req=10: IDLE next cycle, no ack, result unchanged; the held req restarts the transfer and completes with ack=10.
- reset low during SHIFT: all outputs 0 immediately; after release with req=01 the first grant goes to requester 0 and completes normally.
- Back-to-back req=01 held: successive acks exactly 12 cycles apart, busy low for exactly 1 cycle between transfers.
